// File: rtl/motoro3_pkg.sv
// Shared types and constants for the 3-phase step scheduler.
// Period values are always kept at or above PERIOD_MIN.
package motoro3_pkg;

    localparam int unsigned CNT_W      = 25;
    localparam int unsigned STEP_MAX   = 11;
    localparam int unsigned PERIOD_MIN = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAMP     = 2'd1,
        ST_RUN      = 2'd2,
        ST_STOPPING = 2'd3
    } state_e;

    function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
        return (p < CNT_W'(PERIOD_MIN)) ? CNT_W'(PERIOD_MIN) : p;
    endfunction

endpackage

// File: rtl/motoro3_step_scheduler_if.sv
// Control/config and timebase bus between the register file, the scheduler
// and the PWM generator.
interface motoro3_step_scheduler_if;
    import motoro3_pkg::*;

    logic                 start;
    logic                 stop;
    logic [CNT_W-1:0]     m3r_periodStart;
    logic [CNT_W-1:0]     m3r_periodWant;
    logic [15:0]          m3r_periodDec;
    logic [15:0]          m3r_plLenWant;

    logic [CNT_W-1:0]     m3cnt;
    logic                 m3cntLast1;
    logic                 m3cntLast2;
    logic [3:0]           sgStep;
    logic [15:0]          plLen;
    logic                 running;
    logic [15:0]          revCnt;

    modport master (
        output start, stop, m3r_periodStart, m3r_periodWant, m3r_periodDec, m3r_plLenWant,
        input  m3cnt, m3cntLast1, m3cntLast2, sgStep, plLen, running, revCnt
    );

    modport slave (
        input  start, stop, m3r_periodStart, m3r_periodWant, m3r_periodDec, m3r_plLenWant,
        output m3cnt, m3cntLast1, m3cntLast2, sgStep, plLen, running, revCnt
    );

endinterface

// File: rtl/motoro3_step_timebase.sv
// Step timebase: position counter inside a step, end-of-step strobes and the
// 12-step commutation index.
module motoro3_step_timebase
    import motoro3_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] p_eff_i,
    output logic [CNT_W-1:0] m3cnt_o,
    output logic             last1_o,
    output logic             last2_o,
    output logic [3:0]       sg_step_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       step_q, step_d;
    logic             last1, last2;

    always_comb begin
        // p_eff_i is never below PERIOD_MIN, so both strobe positions are distinct and valid
        last1  = enable_i && (cnt_q == p_eff_i - CNT_W'(1));
        last2  = enable_i && (cnt_q == p_eff_i - CNT_W'(2));
        cnt_d  = cnt_q;
        step_d = step_q;
        if (clear_i) begin
            cnt_d  = '0;
            step_d = '0;
        end else if (enable_i) begin
            if (last1) begin
                cnt_d  = '0;
                step_d = (step_q == 4'(STEP_MAX)) ? 4'd0 : step_q + 4'd1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            step_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end

    assign m3cnt_o   = cnt_q;
    assign last1_o   = last1;
    assign last2_o   = last2;
    assign sg_step_o = step_q;

endmodule

// File: rtl/motoro3_step_scheduler.sv
// Step scheduler top: run/stop state machine, open-loop start-up ramp and
// revolution counter around the step timebase.
module motoro3_step_scheduler
    import motoro3_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    motoro3_step_scheduler_if.slave    bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [15:0]      rev_q, rev_d;

    logic [CNT_W-1:0] p_eff;
    logic [CNT_W:0]   ramp_diff;
    logic             ramp_done;
    logic             rev_end;
    logic             tb_enable;
    logic             tb_clear;
    logic             last1;
    logic             last2;
    logic [3:0]       sg_step;
    logic [CNT_W-1:0] m3cnt;
    logic             rotating;

    assign p_eff     = clamp_period(period_q);
    assign tb_enable = (state_q != ST_IDLE);
    assign tb_clear  = (state_q == ST_IDLE);
    assign rev_end   = last1 && (sg_step == 4'(STEP_MAX));
    assign rotating  = (state_q == ST_RAMP) || (state_q == ST_RUN);

    motoro3_step_timebase u_timebase (
        .clk       (clk),
        .rst       (rst),
        .enable_i  (tb_enable),
        .clear_i   (tb_clear),
        .p_eff_i   (p_eff),
        .m3cnt_o   (m3cnt),
        .last1_o   (last1),
        .last2_o   (last2),
        .sg_step_o (sg_step)
    );

    // One extra bit so an oversized decrement shows up as underflow, not a wrap
    assign ramp_diff = {1'b0, period_q} - {{(CNT_W - 15){1'b0}}, bus.m3r_periodDec};
    assign ramp_done = (bus.m3r_periodDec == 16'd0) || ramp_diff[CNT_W] ||
                       (ramp_diff <= {1'b0, bus.m3r_periodWant});

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        rev_d    = rev_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d  = ST_RAMP;
                    period_d = clamp_period(bus.m3r_periodStart);
                    rev_d    = '0;
                end
            end
            ST_RAMP: begin
                if (rev_end) begin
                    rev_d = rev_q + 16'd1;
                    if (ramp_done) begin
                        period_d = clamp_period(bus.m3r_periodWant);
                        state_d  = ST_RUN;
                    end else begin
                        period_d = clamp_period(ramp_diff[CNT_W-1:0]);
                    end
                end
                if (bus.stop) begin
                    state_d = ST_STOPPING;
                end
            end
            ST_RUN: begin
                if (rev_end) begin
                    rev_d    = rev_q + 16'd1;
                    period_d = clamp_period(bus.m3r_periodWant);
                end
                if (bus.stop) begin
                    state_d = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (rev_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            period_q <= CNT_W'(PERIOD_MIN);
            rev_q    <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            rev_q    <= rev_d;
        end
    end

    assign bus.m3cnt      = m3cnt;
    assign bus.m3cntLast1 = last1;
    assign bus.m3cntLast2 = last2;
    assign bus.sgStep     = sg_step;
    // Reset drops the pulse length immediately, before the state register clears
    assign bus.plLen      = (rotating && !rst) ? bus.m3r_plLenWant : 16'd0;
    assign bus.running    = rotating;
    assign bus.revCnt     = rev_q;

endmodule

// File: doc/motoro3_step_scheduler.md
Name: motoro3_step_scheduler

Overview:
- Sequences the 3-phase PWM datapath: generates the step timebase (m3cnt, m3cntLast1, m3cntLast2), the 12-step commutation index sgStep and the per-step pulse length plLen.
- Runs an open-loop start-up ramp (period shrinks once per revolution), then holds the wanted period.
- Sits between the register file (m3r_* config) and the PWM generator / MOS driver logic.

Parameters:
- CNT_W, 25, width of step-period counter m3cnt and period registers.
- STEP_MAX, 11, last commutation step index; sgStep wraps STEP_MAX -> 0.
- PERIOD_MIN, 4, floor applied to every period value used.

Ports:
- clk  input  1  system clock, 10 MHz.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to begin rotation.
- stop  input  1  one-cycle request to end rotation.
- m3r_periodStart  input  CNT_W  step period (clocks) for the first revolution.
- m3r_periodWant  input  CNT_W  target step period in RUN.
- m3r_periodDec  input  16  period decrement applied per revolution in RAMP.
- m3r_plLenWant  input  16  pulse length driven while rotating.
- m3cnt  output  CNT_W  position inside the current step.
- m3cntLast1  output  1  high on the final clock of a step.
- m3cntLast2  output  1  high on the second-to-last clock of a step.
- sgStep  output  4  commutation step index, 0..STEP_MAX.
- plLen  output  16  pulse length to the PWM generator.
- running  output  1  high in RAMP or RUN.
- revCnt  output  16  completed revolutions since start, wraps at 0xFFFF -> 0.

Behaviour:
- Reset, sampled on rising clk only: state IDLE, m3cnt=0, sgStep=0, plLen=0, revCnt=0, periodCur=PERIOD_MIN. m3cntLast1 and m3cntLast2 are 0. running=0.
- Effective period pEff = max(periodCur, PERIOD_MIN). Every config period is clamped the same way when loaded.
- Timebase:
  - In IDLE, m3cnt is held at 0 and neither strobe fires.
  - Otherwise m3cnt increments each clock.
  - m3cntLast2 = (m3cnt == pEff-2). m3cntLast1 = (m3cnt == pEff-1). Both are combinational from registered m3cnt, so the strobes are never simultaneous.
  - On m3cntLast1: m3cnt <= 0, and sgStep <= (sgStep==STEP_MAX) ? 0 : sgStep+1.
- Revolution end: m3cntLast1 while sgStep==STEP_MAX. revCnt increments there (RAMP/RUN only).
- States:
  - IDLE:
    - plLen=0, sgStep=0.
    - start -> RAMP, with periodCur<=m3r_periodStart, m3cnt<=0, revCnt<=0.
  - RAMP:
    - plLen=m3r_plLenWant.
    - At each revolution end: if m3r_periodDec==0 or periodCur-m3r_periodDec <= m3r_periodWant (including underflow), then periodCur<=m3r_periodWant and go to RUN. Otherwise periodCur<=periodCur-m3r_periodDec.
  - RUN:
    - plLen=m3r_plLenWant.
    - periodCur<=m3r_periodWant, reloaded only at revolution end. A mid-revolution config write takes effect at the next revolution.
  - STOPPING:
    - plLen=0, timebase keeps running, running=0.
    - At revolution end -> IDLE (sgStep lands on 0, m3cnt=0).
- stop in RAMP or RUN -> STOPPING on the next clock.
- start or stop in IDLE: only start acts; stop there is ignored.
- start in RAMP, RUN or STOPPING is ignored.
- start and stop in the same cycle: stop wins, so IDLE stays IDLE.
- In RAMP, periodStart < periodWant: the first revolution runs at periodStart, then the block jumps to RUN.
- The m3r_periodDec subtraction uses CNT_W+1 bits, so underflow is detected and no wrap occurs.
- rst asserted mid-step: all state returns to reset values on that edge. plLen=0 takes effect the same cycle.
- Latency: start -> running=1 one clock later. First m3cntLast1 occurs pEff clocks after the transition.

Decomposition:
- Shared package motoro3_pkg:
  - state encoding ST_IDLE / ST_RAMP / ST_RUN / ST_STOPPING (2 bits).
  - STEP_MAX.
  - PERIOD_MIN.
  - CNT_W.
- One natural sub-module, motoro3_step_timebase: m3cnt counter, the two strobes and the sgStep wrap. Its inputs are enable, clear and pEff.
- The state machine, period ramp and revCnt stay in the top module.

Test Plan:
- Reset then start with periodStart=10, periodWant=10, dec=1, plLenWant=0x100:
  - running=1 next clock.
  - m3cntLast2 at m3cnt=8 and m3cntLast1 at m3cnt=9.
  - sgStep steps 0..11; after 120 clocks revCnt=1, state RUN.
  - plLen=0x100 throughout.
- Ramp with periodStart=20, dec=4, want=10:
  - revolution periods are 20, 16, 12, then 10 (12-4=8 <= 10 clamps to want) and stay 10.
  - RUN is entered at the end of the third revolution.
- stop pulsed at sgStep=5:
  - plLen=0 and running=0 next clock.
  - sgStep continues to 11.
  - at that revolution end: IDLE, sgStep=0, m3cnt=0, no further strobes.
- start and stop in the same cycle from IDLE -> stays IDLE. start during RUN -> no change to m3cnt or revCnt.
- periodWant=2 (below floor) -> pEff=4: strobes at m3cnt=2 and 3, never overlapping.
- rst asserted at m3cnt=3, sgStep=7 -> next clock all outputs are at reset values. A later start restarts from sgStep=0.
